// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO and a status register.
// DATA at BASE_ADDR pushes a byte; STATUS at BASE_ADDR+4 reads busy/full/overflow/count and clears overflow on write.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A_dm,
  input  logic [31:0] write_data_dm,
  input  logic        we_dm,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          overflow;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          sel_data, sel_stat, push, pop, baud_end;
  assign sel_data  = A_dm == BASE_ADDR;
  assign sel_stat  = A_dm == BASE_ADDR + 32'd4;
  assign hit       = sel_data | sel_stat;
  assign fifo_full = cnt == (PW+1)'(FIFO_DEPTH);
  assign busy      = cnt != '0 || state != IDLE;
  assign rd_data   = sel_stat ? {16'h0, 8'(cnt), 5'h0, overflow, fifo_full, busy} : 32'h0;
  assign push      = we_dm & sel_data & ~fifo_full;
  assign pop       = state == IDLE && cnt != '0;
  assign baud_end  = baud == BW'(CLKS_PER_BIT - 1);
  // storage needs no reset: count and pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= write_data_dm[7:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (we_dm & sel_data & fifo_full) overflow <= 1'b1;
      else if (we_dm & sel_stat) overflow <= 1'b0;
    end
  always_comb begin
    state_n = state;
    baud_n  = baud + BW'(1);
    bit_n   = bit_cnt;
    shift_n = shift;
    tx_n    = tx;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (pop) begin
          state_n = START;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
        end
      end
      START: if (baud_end) begin
        state_n = DATA;
        baud_n  = '0;
        bit_n   = '0;
        tx_n    = shift[0];
      end
      DATA: if (baud_end) begin
        baud_n = '0;
        if (bit_cnt == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_n   = bit_cnt + 3'd1;
          shift_n = shift >> 1;
          tx_n    = shift[1];
        end
      end
      STOP: if (baud_end) begin
        state_n = IDLE;
        baud_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;
  localparam logic [31:0] DADDR = 32'h0000_0100;
  localparam logic [31:0] SADDR = 32'h0000_0104;
  logic        clk = 1'b0, rst = 1'b0, we_dm = 1'b0;
  logic [31:0] A_dm = '0, write_data_dm = '0;
  logic        hit, tx, busy, fifo_full;
  logic [31:0] rd_data;
  int          checks = 0, errors = 0;
  logic [7:0]  rxq[$];
  logic [7:0]  rx_b;
  logic        rx_ok, quiet;
  logic [39:0] f1, f2, obs40;
  logic [15:0] obs16;

  mmio_uart_tx #(.BASE_ADDR(DADDR), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .A_dm(A_dm), .write_data_dm(write_data_dm), .we_dm(we_dm),
    .hit(hit), .rd_data(rd_data), .tx(tx), .busy(busy), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  // line receiver: samples mid-bit, drops frames touched by reset
  initial forever begin
    @(negedge clk);
    if (rst && tx === 1'b0) begin
      rx_ok = 1'b1;
      repeat (5) begin @(negedge clk); rx_ok &= rst; end
      for (int i = 0; i < 8; i++) begin
        rx_b[i] = tx;
        repeat (4) begin @(negedge clk); rx_ok &= rst; end
      end
      if (rx_ok && tx === 1'b1) rxq.push_back(rx_b);
    end
  end

  function automatic logic [39:0] frame(input logic [7:0] d);
    logic [9:0]  b = {1'b1, d, 1'b0};
    logic [39:0] r;
    for (int i = 0; i < 40; i++) r[i] = b[i/4];
    return r;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    A_dm = a; write_data_dm = d; we_dm = 1'b1;
    @(negedge clk);
    we_dm = 1'b0; A_dm = '0; write_data_dm = '0;
  endtask

  task automatic get_frame(output logic [39:0] o);
    for (int i = 0; i < 40; i++) begin o[i] = tx; @(negedge clk); end
  endtask

  task automatic test_reset;
    rst = 1'b0; A_dm = SADDR;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 00000000", rd_data); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b expected 1", hit); end
    rst = 1'b1; A_dm = '0;
    @(negedge clk);
  endtask

  task automatic test_single;
    rxq.delete();
    wr(DADDR, 32'hFFFF_FFA5);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_prepop_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    @(negedge clk);
    get_frame(f1);
    checks++; if (f1 !== frame(8'hA5)) begin errors++; $display("FAIL single_frame: got %h expected %h", f1, frame(8'hA5)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    A_dm = DADDR; #1;
    checks++; if ({hit, rd_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL data_read: got hit=%b rd=%h expected hit=1 rd=00000000", hit, rd_data); end
    A_dm = 32'h108; #1;
    checks++; if ({hit, rd_data} !== {1'b0, 32'h0}) begin errors++; $display("FAIL miss_read: got hit=%b rd=%h expected hit=0 rd=00000000", hit, rd_data); end
    wr(32'h108, 32'h55);
    repeat (3) @(negedge clk);
    checks++; if ({busy, tx} !== 2'b01) begin errors++; $display("FAIL miss_write: got busy,tx=%b expected 01", {busy, tx}); end
  endtask

  task automatic test_fill_overflow;
    rxq.delete();
    wr(DADDR, 32'h11);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      A_dm = DADDR; write_data_dm = 32'h20 + i; we_dm = 1'b1;
      @(negedge clk);
      if (i == 2) begin checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL fill_3: got %b expected 0", fifo_full); end end
      if (i == 3) begin checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_4: got %b expected 1", fifo_full); end end
    end
    we_dm = 1'b0; A_dm = SADDR; #1;
    checks++; if (rd_data !== 32'h0000_0407) begin errors++; $display("FAIL overflow_status: got %h expected 00000407", rd_data); end
    wr(SADDR, 32'hFFFF_FFFF);
    A_dm = SADDR; #1;
    checks++; if (rd_data !== 32'h0000_0403) begin errors++; $display("FAIL overflow_clear: got %h expected 00000403", rd_data); end
    A_dm = '0;
    for (int n = 0; n < 400 && busy; n++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_drain: got busy=%b expected 0", busy); end
    @(negedge clk);
    obs40 = '0;
    foreach (rxq[j]) obs40 = {obs40[31:0], rxq[j]};
    checks++; if (rxq.size() != 5 || obs40 !== 40'h11_2021_2223) begin errors++; $display("FAIL fill_order: got n=%0d data=%h expected n=5 data=1120212223", rxq.size(), obs40); end
  endtask

  task automatic test_back_to_back;
    wr(DADDR, 32'h00);
    wr(DADDR, 32'hFF);
    get_frame(f1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 1", tx); end
    @(negedge clk);
    get_frame(f2);
    checks++; if (f1 !== frame(8'h00)) begin errors++; $display("FAIL b2b_frame1: got %h expected %h", f1, frame(8'h00)); end
    checks++; if (f2 !== frame(8'hFF)) begin errors++; $display("FAIL b2b_frame2: got %h expected %h", f2, frame(8'hFF)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_push_pop;
    rxq.delete();
    wr(DADDR, 32'h96);
    wr(DADDR, 32'h69);
    A_dm = SADDR; #1;
    checks++; if (rd_data !== 32'h0000_0101) begin errors++; $display("FAIL pushpop_count: got %h expected 00000101", rd_data); end
    A_dm = '0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    @(negedge clk);
    obs16 = '0;
    foreach (rxq[j]) obs16 = {obs16[7:0], rxq[j]};
    checks++; if (rxq.size() != 2 || obs16 !== 16'h9669) begin errors++; $display("FAIL pushpop_order: got n=%0d data=%h expected n=2 data=9669", rxq.size(), obs16); end
  endtask

  task automatic test_reset_mid;
    rxq.delete();
    wr(DADDR, 32'h3C);
    wr(DADDR, 32'h5A);
    repeat (10) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_precheck: got tx=%b expected 0", tx); end
    #2 rst = 1'b0; A_dm = SADDR;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx_async: got %b expected 1", tx); end
    checks++; if ({rd_data, fifo_full} !== 33'h0) begin errors++; $display("FAIL mid_status: got rd=%h full=%b expected rd=00000000 full=0", rd_data, fifo_full); end
    repeat (2) @(negedge clk);
    rst = 1'b1; A_dm = '0; quiet = 1'b1;
    repeat (60) begin @(negedge clk); quiet &= tx; end
    checks++; if ({quiet, busy} !== 2'b10) begin errors++; $display("FAIL mid_no_residual: got quiet,busy=%b expected 10", {quiet, busy}); end
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL mid_rx_empty: got %0d frames expected 0", rxq.size()); end
    wr(DADDR, 32'hC3);
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    @(negedge clk);
    obs16 = {8'(rxq.size()), (rxq.size() > 0) ? rxq[0] : 8'h00};
    checks++; if (obs16 !== 16'h01C3) begin errors++; $display("FAIL mid_after: got n,data=%h expected 01c3", obs16); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_fill_overflow;
    test_back_to_back;
    test_push_pop;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the MCU data-memory store port, downstream of the core.
- Decodes the core's data-memory address, write data and write enable (A_dm, write_data_dm, we_dm).
- Stores bytes written to its data register in a small FIFO, then serialises them as 8N1 frames on a single tx line.
- Provides a status register that the core reads back through the load-result path.

Parameters:
- BASE_ADDR, 32'h0000_0100, word address of the DATA register. STATUS is at BASE_ADDR+4.
- CLKS_PER_BIT, 16, clock cycles per UART bit. Must be ≥ 2.
- FIFO_DEPTH, 4, number of FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- A_dm, input, 32, data-memory address from the core.
- write_data_dm, input, 32, store data from the core.
- we_dm, input, 1, store enable from the core.
- hit, output, 1, combinational; high when A_dm equals BASE_ADDR or BASE_ADDR+4.
- rd_data, output, 32, combinational status/readback word; 0 when not hit.
- tx, output, 1, registered serial output; idles high.
- busy, output, 1, high when the FIFO is non-empty or the transmitter is not IDLE.
- fifo_full, output, 1, high when the FIFO count equals FIFO_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, FIFO count=0, read/write pointers=0, state=IDLE, overflow=0, busy=0, fifo_full=0.
  - Reset asserted mid-frame aborts the frame immediately: tx returns to 1 and the FIFO contents are discarded.
- Register map:
  - DATA (BASE_ADDR): write only; reads return 0.
  - STATUS (BASE_ADDR+4): rd_data[0]=busy, [1]=fifo_full, [2]=overflow, [15:8]=FIFO count (zero-extended), all other bits 0.
- Push:
  - A push happens on an edge where we_dm=1, A_dm=BASE_ADDR and fifo_full=0.
  - write_data_dm[7:0] is stored; bits [31:8] are ignored.
  - The write pointer wraps modulo FIFO_DEPTH.
- Overflow:
  - A DATA write while fifo_full=1 is dropped and sets overflow (sticky).
  - fifo_full is evaluated on the registered count, so the write is dropped even if a pop happens on the same edge.
- Overflow clear: any write to STATUS clears overflow. The write data is ignored.
- Simultaneous push and pop (FIFO not full): count is unchanged and both pointers advance.
- Writes to addresses outside the two registers are ignored; hit=0.
- TX state machine, states IDLE, START, DATA, STOP, with a bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1):
  - IDLE: tx=1. If count>0 on an edge: pop the head byte into the shift register, tx<=0, clear the baud counter, go to START.
  - START: hold for CLKS_PER_BIT cycles, then tx<=shift[0], bit counter=0, go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT cycles, LSB first. After bit 7, tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency:
  - A DATA write on edge k drives tx low from edge k+1 when idle.
  - A frame is exactly 10*CLKS_PER_BIT cycles of line time.
  - Back-to-back frames have exactly one IDLE cycle (tx=1) between the end of STOP and the next start bit.
- tx only changes on baud boundaries or state entry; it is glitch-free and registered.

Test Plan:
- Reset with CLKS_PER_BIT=4: hold rst=0 for 3 cycles → tx=1, busy=0, fifo_full=0, rd_data at STATUS = 32'h0.
- Single byte: write 32'hFFFF_FFA5 to DATA → tx low at edge k+1, then bits 1,0,1,0,0,1,0,1 (LSB first) for 4 cycles each, stop high; busy returns to 0 after 40+1 cycles.
- Fill and overflow (DEPTH=4, with the transmitter already sending one frame): 5 further back-to-back DATA writes → fifo_full=1 after the 4th, the 5th is dropped, STATUS[2]=1 and STATUS[15:8]=4; writing STATUS clears bit 2.
- Back-to-back frames: write 8'h00 then 8'hFF → two complete frames separated by exactly one tx=1 idle cycle; pointers wrap correctly after 5 or more total writes.
- Simultaneous push/pop: issue a DATA write on the same edge that IDLE pops (count=1) → count stays 1, byte order is preserved.
- Reset mid-frame: assert rst during the DATA state → tx=1 asynchronously, count=0. After release, no residual frame is sent; a new write transmits normally.
